spi_reg_responder: RTL and testbench

SPI mode-0 slave with a 32 × 8 register file. It is the responder end of the link our SoC's SPI master (MISO/MOSI/SCLK/SS_n) drives toward the USB host controller. It lets us emulate that controller's register interface in simulation or on a second FPGA, and exposes register contents and write strobes to local logic. The command byte and status-byte format match the controller: address in cmd[7:3], direction in cmd[1], and status shifted out during the command byte.

---
 rtl/spi_resp_pkg.sv | 17 +
 rtl/spi_reg_responder_if.sv | 24 ++
 rtl/spi_in_sync.sv | 34 +++
 rtl/spi_reg_responder.sv | 199 +++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte field positions for the SPI register responder.
package spi_resp_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 5;

  // Command byte layout: address in [7:3], direction in [1] (1 = write).
  localparam int unsigned CMD_ADDR_MSB = 7;
  localparam int unsigned CMD_ADDR_LSB = 3;
  localparam int unsigned CMD_RW_BIT   = 1;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle between an SPI master and the register responder.
interface spi_reg_responder_if;
  logic spi_sclk;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_ss_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_ss_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer with registered rise/fall detection for one async SPI pin.
module spi_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, level_q, rise_q, fall_q;

  // Reset to 0 so that SS_n held low across reset never produces a select edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      level_q <= sync_q;
      rise_q  <= sync_q & ~level_q;
      fall_q  <= ~sync_q & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave exposing a 2^ADDR_W x 8 register file, with a local
// write/read port and a write-strobe output for each committed SPI write.
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned MIN_RATIO = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_reg_responder_if.slave spi,
  input  logic [7:0]        status_in,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned unused_min_ratio = MIN_RATIO;

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;

  spi_in_sync u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.spi_sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_in_sync u_sync_ss (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.spi_ss_n),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_in_sync u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.spi_mosi),
    .level (mosi_level),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  logic sel, desel, rise_ev, fall_ev;
  assign sel     = ss_fall;
  assign desel   = ss_rise;
  assign rise_ev = sclk_rise & ~ss_level;
  assign fall_ev = sclk_fall & ~ss_level;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        loc_rdata_q;
  logic [7:0]        regs_q [Depth];

  logic              commit;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_inc;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    commit    = 1'b0;
    rx_byte   = {rx_q[6:0], mosi_level};
    cmd_addr  = ADDR_W'(rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
    addr_inc  = addr_q + ADDR_W'(1);

    // DESEL wins over everything, including a byte completing in the same cycle.
    if (desel) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sel) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b1;
            miso_d    = status_in[7];
            tx_d      = {status_in[6:0], 1'b0};
          end
        end
        StCmd, StData: begin
          if (rise_ev) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StCmd) begin
                state_d = StData;
                addr_d  = cmd_addr;
                rw_d    = rx_byte[CMD_RW_BIT];
                tx_d    = rx_byte[CMD_RW_BIT] ? 8'h00 : regs_q[cmd_addr];
              end else begin
                addr_d = addr_inc;
                if (rw_q) begin
                  commit = 1'b1;
                  tx_d   = 8'h00;
                end else begin
                  tx_d = regs_q[addr_inc];
                end
              end
            end
          end else if (fall_ev) begin
            // The next bit to send always sits in tx_q[7].
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      wr_valid_q <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  // SPI write is applied last so it overrides a same-address local write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs_q[i] <= 8'h00;
      end
      loc_rdata_q <= 8'h00;
    end else begin
      if (loc_we) begin
        regs_q[loc_addr] <= loc_wdata;
      end
      if (commit) begin
        regs_q[addr_q] <= rx_byte;
      end
      loc_rdata_q <= regs_q[loc_addr];
    end
  end

  assign spi.spi_miso    = miso_q & oe_q;
  assign spi.spi_miso_oe = oe_q;
  assign loc_rdata       = loc_rdata_q;
  assign wr_valid        = wr_valid_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Scoreboard bench for spi_reg_responder: directed SPI transactions, queued
// expectations for write strobes and MISO bytes, checked by a monitor process.
module tb_spi_reg_responder;
  import spi_resp_pkg::*;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    status_in;
  logic          loc_we;
  logic [AW-1:0] loc_addr;
  logic [7:0]    loc_wdata;
  logic [7:0]    loc_rdata;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  always #5 clk = ~clk;

  spi_reg_responder_if spi_if ();

  spi_reg_responder #(
    .ADDR_W    (AW),
    .MIN_RATIO (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi_if),
    .status_in (status_in),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         oe_hi_cnt = 0;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] got_miso_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // Monitor: compares every write strobe and every captured MISO byte against the queues.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_valid) begin
      check("wr_valid expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    while (got_miso_q.size() != 0 && exp_miso_q.size() != 0) begin
      check("miso byte", 32'(got_miso_q.pop_front()), 32'(exp_miso_q.pop_front()));
    end
    if (spi_if.spi_miso_oe === 1'b1) oe_hi_cnt++;
  end

  // Shift nbits (MSB first) in mode 0; optionally fire a local write aligned with
  // the DUT's commit of the last bit.
  task automatic spi_xfer(input logic [7:0] mosi_b, input int nbits, input logic chk,
                          input logic [7:0] exp_b, input logic coll,
                          input logic [AW-1:0] caddr, input logic [7:0] cdata);
    logic [7:0] got = 8'h00;
    if (chk) exp_miso_q.push_back(exp_b);
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_if.spi_mosi = mosi_b[i];
      repeat (8) @(negedge clk);
      got[i] = spi_if.spi_miso;
      spi_if.spi_sclk = 1'b1;
      if (coll && i == 0) begin
        repeat (3) @(negedge clk);
        loc_addr  = caddr;
        loc_wdata = cdata;
        loc_we    = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      spi_if.spi_sclk = 1'b0;
    end
    if (chk) got_miso_q.push_back(got);
  endtask

  task automatic byte_chk(input logic [7:0] mosi_b, input logic [7:0] exp_b);
    spi_xfer(mosi_b, 8, 1'b1, exp_b, 1'b0, '0, 8'h00);
  endtask

  task automatic byte_nc(input logic [7:0] mosi_b, input int nbits);
    spi_xfer(mosi_b, nbits, 1'b0, 8'h00, 1'b0, '0, 8'h00);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic select();
    spi_if.spi_ss_n = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic deselect();
    repeat (8) @(negedge clk);
    spi_if.spi_ss_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr  = a;
    loc_wdata = d;
    loc_we    = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic loc_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    loc_addr = a;
    repeat (2) @(negedge clk);
    check(name, 32'(loc_rdata), 32'(exp));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    int oe_before;
    rst             = 1'b1;
    status_in       = 8'h00;
    loc_we          = 1'b0;
    loc_addr        = '0;
    loc_wdata       = 8'h00;
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_ss_n = 1'b1;
    spi_if.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    check("reset miso", 32'(spi_if.spi_miso), 32'd0);
    check("reset oe", 32'(spi_if.spi_miso_oe), 32'd0);
    check("reset wr_valid", 32'(wr_valid), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset loc_rdata", 32'(loc_rdata), 32'd0);

    // Status shift during a write command to addr 2 with no data byte.
    status_in = 8'hA5;
    select();
    check("oe after select", 32'(spi_if.spi_miso_oe), 32'd1);
    byte_chk(8'h12, 8'hA5);
    deselect();
    check("oe after deselect", 32'(spi_if.spi_miso_oe), 32'd0);
    check("miso after deselect", 32'(spi_if.spi_miso), 32'd0);
    loc_check("reg2 untouched", 5'd2, 8'h00);

    // Write burst from addr 1; MISO is 0 during write data.
    status_in = 8'h00;
    select();
    byte_chk(8'h0A, 8'h00);
    expect_wr(5'd1, 8'h11);
    byte_chk(8'h11, 8'h00);
    expect_wr(5'd2, 8'h22);
    byte_chk(8'h22, 8'h00);
    expect_wr(5'd3, 8'h33);
    byte_chk(8'h33, 8'h00);
    deselect();
    loc_check("reg1", 5'd1, 8'h11);
    loc_check("reg2", 5'd2, 8'h22);
    loc_check("reg3", 5'd3, 8'h33);

    // Read across the wrap from 31 to 0.
    loc_write(5'd31, 8'h5A);
    loc_write(5'd0, 8'hC3);
    status_in = 8'h3C;
    select();
    byte_chk(8'hF8, 8'h3C);
    byte_chk(8'h00, 8'h5A);
    byte_chk(8'h00, 8'hC3);
    deselect();

    // Abort mid-byte: no write, then a normal write to the same address.
    select();
    byte_chk(8'h22, 8'h3C);
    byte_nc(8'hFF, 5);
    deselect();
    loc_check("reg4 after abort", 5'd4, 8'h00);
    select();
    byte_nc(8'h22, 8);
    expect_wr(5'd4, 8'h44);
    byte_nc(8'h44, 8);
    deselect();
    loc_check("reg4 after write", 5'd4, 8'h44);

    // Collision with a local write in the commit cycle.
    loc_write(5'd6, 8'h01);
    select();
    byte_nc(8'h32, 8);
    expect_wr(5'd6, 8'h77);
    spi_xfer(8'h77, 8, 1'b0, 8'h00, 1'b1, 5'd6, 8'h99);
    deselect();
    loc_check("reg6 same-addr collision", 5'd6, 8'h77);
    select();
    byte_nc(8'h32, 8);
    expect_wr(5'd6, 8'h77);
    spi_xfer(8'h77, 8, 1'b0, 8'h00, 1'b1, 5'd7, 8'h99);
    deselect();
    loc_check("reg7 diff-addr collision", 5'd7, 8'h99);
    loc_check("reg6 diff-addr collision", 5'd6, 8'h77);

    // Reset mid-read with SS_n held low; SCLK must be ignored until a fresh select.
    status_in = 8'hA5;
    select();
    byte_nc(8'hF8, 8);
    byte_nc(8'h00, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("oe after mid reset", 32'(spi_if.spi_miso_oe), 32'd0);
    loc_check("reg1 cleared by reset", 5'd1, 8'h00);
    oe_before = oe_hi_cnt;
    byte_nc(8'h0A, 8);
    byte_nc(8'hFF, 8);
    repeat (8) @(negedge clk);
    check("oe stays low after reset", 32'(oe_hi_cnt - oe_before), 32'd0);
    check("miso low after reset", 32'(spi_if.spi_miso), 32'd0);
    spi_if.spi_ss_n = 1'b1;
    repeat (12) @(negedge clk);
    select();
    check("oe after fresh select", 32'(spi_if.spi_miso_oe), 32'd1);
    byte_chk(8'h0A, 8'hA5);
    expect_wr(5'd1, 8'h5C);
    byte_nc(8'h5C, 8);
    deselect();
    loc_check("reg1 after recovery", 5'd1, 8'h5C);

    repeat (10) @(negedge clk);
    check("pending wr expectations", 32'(exp_wr_q.size()), 32'd0);
    check("pending miso expectations", 32'(exp_miso_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
